imu_spi_responder: RTL and testbench

IMU_SPI_RESPONDER -- requirements
Module: imu_spi_responder

---
 rtl/imu_spi_pkg.sv | 32 +++
 rtl/imu_spi_responder_shifter.sv | 79 +++++++
 rtl/imu_spi_responder.sv | 166 ++++++++++++++++
 tb/tb_imu_spi_responder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/imu_spi_pkg.sv
// Shared constants for the IMU SPI responder: FSM encoding, default register
// addresses and the offsets of the 12 sensor-data bytes.
package imu_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } spi_state_e;

  localparam logic [6:0] DEF_WHO_AM_I_ADDR   = 7'h75;
  localparam logic [7:0] DEF_WHO_AM_I_VALUE  = 8'h47;
  localparam logic [6:0] DEF_DATA_BASE_ADDR  = 7'h1F;
  localparam logic [6:0] DEF_INT_STATUS_ADDR = 7'h3A;
  localparam logic [6:0] DEF_SCRATCH_ADDR    = 7'h6B;

  localparam logic [6:0] NUM_DATA_REGS = 7'd12;

  localparam logic [3:0] OFF_AX_H = 4'd0;
  localparam logic [3:0] OFF_AX_L = 4'd1;
  localparam logic [3:0] OFF_AY_H = 4'd2;
  localparam logic [3:0] OFF_AY_L = 4'd3;
  localparam logic [3:0] OFF_AZ_H = 4'd4;
  localparam logic [3:0] OFF_AZ_L = 4'd5;
  localparam logic [3:0] OFF_GX_H = 4'd6;
  localparam logic [3:0] OFF_GX_L = 4'd7;
  localparam logic [3:0] OFF_GY_H = 4'd8;
  localparam logic [3:0] OFF_GY_L = 4'd9;
  localparam logic [3:0] OFF_GZ_H = 4'd10;
  localparam logic [3:0] OFF_GZ_L = 4'd11;

endpackage

// File: rtl/imu_spi_responder_shifter.sv
// SPI mode-3 bit engine: synchronises the SPI pins into clk, detects edges,
// assembles received bytes and shifts the transmit byte out MSB first.
module spi_slave_shifter (
  input  logic       clk,
  input  logic       resetn,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  input  logic [7:0] tx_byte,
  output logic       cs_high,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       miso_bit
);

  logic       sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic       cs_meta_r, cs_sync_r, cs_prev_r;
  logic       mosi_meta_r, mosi_sync_r;
  logic [2:0] bit_cnt_r;
  logic [6:0] rx_shift_r;
  logic [7:0] tx_shift_r;
  logic       miso_r;
  logic       sclk_rise_s, sclk_fall_s;

  assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_sync_r & sclk_prev_r;
  assign cs_high     = cs_sync_r;
  assign cs_fall     = ~cs_sync_r & cs_prev_r;
  assign cs_rise     = cs_sync_r & ~cs_prev_r;
  // The 8th rising edge completes a byte; the live MOSI bit is its LSB.
  assign byte_done   = ~cs_sync_r & sclk_rise_s & (bit_cnt_r == 3'd7);
  assign rx_byte     = {rx_shift_r, mosi_sync_r};
  assign miso_bit    = miso_r;

  // Synchronisers, bit counter and rx/tx shift registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sclk_meta_r <= 1'b1;
      sclk_sync_r <= 1'b1;
      sclk_prev_r <= 1'b1;
      cs_meta_r   <= 1'b1;
      cs_sync_r   <= 1'b1;
      cs_prev_r   <= 1'b1;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
      bit_cnt_r   <= 3'd0;
      rx_shift_r  <= 7'd0;
      tx_shift_r  <= 8'd0;
      miso_r      <= 1'b0;
    end else begin
      sclk_meta_r <= spi_clk;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      cs_meta_r   <= spi_cs;
      cs_sync_r   <= cs_meta_r;
      cs_prev_r   <= cs_sync_r;
      mosi_meta_r <= spi_mosi;
      mosi_sync_r <= mosi_meta_r;
      if (cs_sync_r) begin
        bit_cnt_r  <= 3'd0;
        rx_shift_r <= 7'd0;
        tx_shift_r <= 8'd0;
        miso_r     <= 1'b0;
      end else if (sclk_rise_s) begin
        rx_shift_r <= {rx_shift_r[5:0], mosi_sync_r};
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          tx_shift_r <= tx_byte;
        end
      end else if (sclk_fall_s) begin
        miso_r     <= tx_shift_r[7];
        tx_shift_r <= {tx_shift_r[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/imu_spi_responder.sv
// IMU-style SPI responder: command/data FSM, register map with one writable
// scratch byte, and a counter-based sensor model with coherent snapshots.
module imu_spi_responder
  import imu_spi_pkg::*;
#(
  parameter logic [6:0] WHO_AM_I_ADDR   = DEF_WHO_AM_I_ADDR,
  parameter logic [7:0] WHO_AM_I_VALUE  = DEF_WHO_AM_I_VALUE,
  parameter logic [6:0] DATA_BASE_ADDR  = DEF_DATA_BASE_ADDR,
  parameter logic [6:0] INT_STATUS_ADDR = DEF_INT_STATUS_ADDR,
  parameter logic [6:0] SCRATCH_ADDR    = DEF_SCRATCH_ADDR
) (
  input  logic clk,
  input  logic resetn,
  input  logic sample_trigger,
  input  logic spi_clk,
  input  logic spi_cs,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic imu_int
);

  spi_state_e  state_r, state_nx_s;
  logic        cs_high_s, cs_fall_s, cs_rise_s, byte_done_s, shift_miso_s;
  logic [7:0]  rx_byte_s, tx_byte_s, reg_rd_s;
  logic [6:0]  rd_addr_s, off_s, addr_r;
  logic        rd_en_s, miso_nx_s, update_s;
  logic        is_read_r, int_armed_r, int_read_r, pending_r, imu_int_r, spi_miso_r;
  logic [7:0]  scratch_r;
  logic [15:0] gx_r, gy_r, gz_r, ax_r, ay_r, az_r, gx_nx_s;

  spi_slave_shifter u_shifter (
    .clk       (clk),
    .resetn    (resetn),
    .spi_clk   (spi_clk),
    .spi_cs    (spi_cs),
    .spi_mosi  (spi_mosi),
    .tx_byte   (tx_byte_s),
    .cs_high   (cs_high_s),
    .cs_fall   (cs_fall_s),
    .cs_rise   (cs_rise_s),
    .byte_done (byte_done_s),
    .rx_byte   (rx_byte_s),
    .miso_bit  (shift_miso_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) state_r <= ST_IDLE;
    else         state_r <= state_nx_s;
  end

  // FSM next-state logic; a high chip select always returns to idle.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: if (cs_fall_s)   state_nx_s = ST_CMD;  else state_nx_s = ST_IDLE;
      ST_CMD:  if (cs_high_s)   state_nx_s = ST_IDLE;
               else if (byte_done_s) state_nx_s = ST_DATA;
               else             state_nx_s = ST_CMD;
      ST_DATA: if (cs_high_s)   state_nx_s = ST_IDLE; else state_nx_s = ST_DATA;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM outputs: which address feeds the transmitter and the gated MISO.
  always_comb begin
    rd_addr_s = addr_r;
    rd_en_s   = 1'b0;
    if (state_r == ST_CMD) begin
      rd_addr_s = rx_byte_s[6:0];
      rd_en_s   = rx_byte_s[7];
    end else if (state_r == ST_DATA) begin
      rd_addr_s = addr_r;
      rd_en_s   = is_read_r;
    end else begin
      rd_addr_s = addr_r;
      rd_en_s   = 1'b0;
    end
    tx_byte_s = rd_en_s ? reg_rd_s : 8'h00;
    miso_nx_s = ((state_r == ST_DATA) && !cs_high_s) ? shift_miso_s : 1'b0;
  end

  // Register map read decode.
  always_comb begin
    off_s    = rd_addr_s - DATA_BASE_ADDR;
    reg_rd_s = 8'h00;
    if (rd_addr_s == WHO_AM_I_ADDR)        reg_rd_s = WHO_AM_I_VALUE;
    else if (rd_addr_s == INT_STATUS_ADDR) reg_rd_s = {7'b0, imu_int_r};
    else if (rd_addr_s == SCRATCH_ADDR)    reg_rd_s = scratch_r;
    else if (off_s < NUM_DATA_REGS) begin
      case (off_s[3:0])
        OFF_AX_H: reg_rd_s = ax_r[15:8];
        OFF_AX_L: reg_rd_s = ax_r[7:0];
        OFF_AY_H: reg_rd_s = ay_r[15:8];
        OFF_AY_L: reg_rd_s = ay_r[7:0];
        OFF_AZ_H: reg_rd_s = az_r[15:8];
        OFF_AZ_L: reg_rd_s = az_r[7:0];
        OFF_GX_H: reg_rd_s = gx_r[15:8];
        OFF_GX_L: reg_rd_s = gx_r[7:0];
        OFF_GY_H: reg_rd_s = gy_r[15:8];
        OFF_GY_L: reg_rd_s = gy_r[7:0];
        OFF_GZ_H: reg_rd_s = gz_r[15:8];
        OFF_GZ_L: reg_rd_s = gz_r[7:0];
        default:  reg_rd_s = 8'h00;
      endcase
    end else reg_rd_s = 8'h00;
  end

  // Transaction bookkeeping: address pointer, scratch writes, status-read tracking.
  // In read mode addr_r names the next byte to load; in write mode the byte being received.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_r      <= 7'd0;
      is_read_r   <= 1'b0;
      int_armed_r <= 1'b0;
      int_read_r  <= 1'b0;
      scratch_r   <= 8'h00;
      spi_miso_r  <= 1'b0;
    end else begin
      spi_miso_r <= miso_nx_s;
      if (state_r == ST_IDLE) begin
        int_armed_r <= 1'b0;
        int_read_r  <= 1'b0;
      end else if ((state_r == ST_CMD) && byte_done_s) begin
        is_read_r   <= rx_byte_s[7];
        addr_r      <= rx_byte_s[7] ? rx_byte_s[6:0] + 7'd1 : rx_byte_s[6:0];
        int_armed_r <= rx_byte_s[7] && (rx_byte_s[6:0] == INT_STATUS_ADDR);
      end else if ((state_r == ST_DATA) && byte_done_s) begin
        addr_r <= addr_r + 7'd1;
        if (!is_read_r && (addr_r == SCRATCH_ADDR)) scratch_r <= rx_byte_s;
        if (int_armed_r) int_read_r <= 1'b1;
        int_armed_r <= is_read_r && (addr_r == INT_STATUS_ADDR);
      end
    end
  end

  assign update_s = (sample_trigger | pending_r) & cs_high_s;
  assign gx_nx_s  = gx_r + 16'd1;

  // Sensor model and interrupt; updates wait for chip select high, and win over a clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      gx_r <= 16'd0; gy_r <= 16'd0; gz_r <= 16'd0;
      ax_r <= 16'd0; ay_r <= 16'd0; az_r <= 16'd0;
      pending_r <= 1'b0;
      imu_int_r <= 1'b0;
    end else begin
      pending_r <= (sample_trigger | pending_r) & ~cs_high_s;
      if (update_s) begin
        gx_r <= gx_nx_s;
        gy_r <= gx_nx_s + 16'd1;
        gz_r <= gx_nx_s + 16'd2;
        ax_r <= gx_nx_s + 16'd3;
        ay_r <= gx_nx_s + 16'd4;
        az_r <= gx_nx_s + 16'd5;
        imu_int_r <= 1'b1;
      end else if (cs_rise_s && int_read_r) begin
        imu_int_r <= 1'b0;
      end
    end
  end

  assign spi_miso = spi_miso_r;
  assign imu_int  = imu_int_r;

endmodule

// File: tb/tb_imu_spi_responder.sv
// Directed bench for imu_spi_responder: SPI mode-3 controller model driving
// hand-computed transactions, checked with immediate assertions.
module tb_imu_spi_responder;

  logic clk = 1'b0;
  logic resetn, sample_trigger, spi_clk, spi_cs, spi_mosi;
  logic spi_miso, imu_int;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] rx_buf [12];
  logic [7:0] rx_b;
  logic [7:0] snap_a [12];
  logic [7:0] snap_b [12];
  logic [7:0] snap_z [12];

  always #5 clk = ~clk;

  imu_spi_responder dut (
    .clk            (clk),
    .resetn         (resetn),
    .sample_trigger (sample_trigger),
    .spi_clk        (spi_clk),
    .spi_cs         (spi_cs),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .imu_int        (imu_int)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // One SPI byte (or its first nbits), MSB first; MISO sampled just before each rising edge.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_clk  = 1'b0;
      spi_mosi = tx[i];
      wait_clk(8);
      rx[i]    = spi_miso;
      spi_clk  = 1'b1;
      wait_clk(8);
    end
  endtask

  task automatic cs_begin();
    spi_cs = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_end();
    wait_clk(8);
    spi_cs = 1'b1;
    wait_clk(8);
  endtask

  task automatic pulse_trigger();
    sample_trigger = 1'b1;
    wait_clk(1);
    sample_trigger = 1'b0;
    wait_clk(3);
  endtask

  // Leaves chip select low so the caller can look at imu_int before ending.
  task automatic burst_read(input logic [7:0] cmd, input int n, input int trig_after);
    logic [7:0] tmp;
    cs_begin();
    xfer(cmd, 8, tmp);
    check("miso_during_cmd", tmp, 8'h00);
    for (int i = 0; i < n; i++) begin
      if (i == trig_after) pulse_trigger();
      xfer(8'h00, 8, tmp);
      rx_buf[i] = tmp;
    end
  endtask

  task automatic write_byte(input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] tmp;
    cs_begin();
    xfer(cmd, 8, tmp);
    xfer(data, 8, tmp);
    cs_end();
  endtask

  task automatic check_burst(input string tag, input logic [7:0] exp [12]);
    for (int i = 0; i < 12; i++) check($sformatf("%s[%0d]", tag, i), rx_buf[i], exp[i]);
  endtask

  initial begin
    // gx=4 snapshot, then gx=5 snapshot, then post-reset zeros
    snap_a = '{8'h00, 8'h07, 8'h00, 8'h08, 8'h00, 8'h09, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00, 8'h06};
    snap_b = '{8'h00, 8'h08, 8'h00, 8'h09, 8'h00, 8'h0A, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 8'h07};
    snap_z = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    resetn = 1'b0; sample_trigger = 1'b0;
    spi_clk = 1'b1; spi_cs = 1'b1; spi_mosi = 1'b0;
    wait_clk(5);
    check("reset_miso", {7'b0, spi_miso}, 8'h00);
    check("reset_int", {7'b0, imu_int}, 8'h00);
    resetn = 1'b1;
    wait_clk(4);

    burst_read(8'hF5, 1, -1); cs_end();
    check("who_am_i", rx_buf[0], 8'h47);

    pulse_trigger(); pulse_trigger();
    check("int_after_trig", {7'b0, imu_int}, 8'h01);
    burst_read(8'hBA, 1, -1);
    check("int_status_1", rx_buf[0], 8'h01);
    cs_end();
    check("int_cleared_1", {7'b0, imu_int}, 8'h00);

    pulse_trigger(); pulse_trigger();
    check("int_before_burst", {7'b0, imu_int}, 8'h01);
    burst_read(8'h9F, 12, -1); cs_end();
    check_burst("burst_gx4", snap_a);

    write_byte(8'h6B, 8'hA5);
    burst_read(8'hEB, 1, -1); cs_end();
    check("scratch_rd", rx_buf[0], 8'hA5);
    write_byte(8'h1F, 8'hFF);
    burst_read(8'h9F, 1, -1); cs_end();
    check("ax_h_ro", rx_buf[0], 8'h00);
    burst_read(8'hEA, 2, -1); cs_end();
    check("unmapped_6a", rx_buf[0], 8'h00);
    check("autoinc_6b", rx_buf[1], 8'hA5);

    burst_read(8'hBA, 1, -1);
    check("int_status_2", rx_buf[0], 8'h01);
    cs_end();
    check("int_cleared_2", {7'b0, imu_int}, 8'h00);

    burst_read(8'h9F, 12, 3);
    check("int_deferred", {7'b0, imu_int}, 8'h00);
    cs_end();
    check("int_after_defer", {7'b0, imu_int}, 8'h01);
    check_burst("burst_coherent", snap_a);
    burst_read(8'h9F, 12, -1); cs_end();
    check_burst("burst_gx5", snap_b);

    cs_begin();
    xfer(8'hBA, 8, rx_b);
    xfer(8'h00, 4, rx_b);
    cs_end();
    check("int_partial_kept", {7'b0, imu_int}, 8'h01);
    burst_read(8'hBA, 1, -1);
    check("int_status_3", rx_buf[0], 8'h01);
    cs_end();
    check("int_cleared_3", {7'b0, imu_int}, 8'h00);

    // gx=6 so AX_L = 0x09; stop after 5 bits with MISO showing bit 3 = 1
    pulse_trigger();
    cs_begin();
    xfer(8'hA0, 8, rx_b);
    xfer(8'h00, 5, rx_b);
    check("ax_l_partial", rx_b, 8'h08);
    resetn = 1'b0;
    wait_clk(4);
    check("midreset_miso", {7'b0, spi_miso}, 8'h00);
    check("midreset_int", {7'b0, imu_int}, 8'h00);
    spi_cs = 1'b1; spi_clk = 1'b1;
    wait_clk(4);
    resetn = 1'b1;
    wait_clk(4);
    burst_read(8'h9F, 12, -1); cs_end();
    check_burst("burst_after_reset", snap_z);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
